// File: rtl/yuv422_packer.sv
// Packs a YUV 4:4:4 pixel stream into 4:2:2 words {Y0, U, Y1, V}.
// Chroma is averaged (rounded half-up) over horizontal pixel pairs; odd lines end with a padded word.
module yuv422_packer #(
  parameter int unsigned BW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [BW-1:0]   i_y,
  input  logic [BW-1:0]   i_u,
  input  logic [BW-1:0]   i_v,
  input  logic            i_last,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [4*BW-1:0] o_data,
  output logic            o_last
);

  typedef enum logic {EVEN, ODD} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     hold_y_q, hold_y_d;
  logic [BW-1:0]     hold_u_q, hold_u_d;
  logic [BW-1:0]     hold_v_q, hold_v_d;
  logic [4*BW-1:0]   data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  logic              in_xfer;
  logic [BW:0]       u_sum, v_sum;

  assign i_ready = !valid_q || o_ready;
  assign in_xfer = i_valid && i_ready;

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;

  // One extra bit keeps the rounding carry, so 255+255+1 averages to 255.
  assign u_sum = {1'b0, hold_u_q} + {1'b0, i_u} + {{BW{1'b0}}, 1'b1};
  assign v_sum = {1'b0, hold_v_q} + {1'b0, i_v} + {{BW{1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    hold_y_d = hold_y_q;
    hold_u_d = hold_u_q;
    hold_v_d = hold_v_q;
    data_d   = data_q;
    last_d   = last_q;
    valid_d  = valid_q && !o_ready;

    if (in_xfer) begin
      unique case (state_q)
        EVEN: begin
          if (i_last) begin
            data_d  = {i_y, i_u, i_y, i_v};
            last_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            hold_y_d = i_y;
            hold_u_d = i_u;
            hold_v_d = i_v;
            state_d  = ODD;
          end
        end
        ODD: begin
          data_d  = {hold_y_q, u_sum[BW:1], i_y, v_sum[BW:1]};
          last_d  = i_last;
          valid_d = 1'b1;
          state_d = EVEN;
        end
        default: state_d = EVEN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EVEN;
      hold_y_q <= '0;
      hold_u_q <= '0;
      hold_v_q <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_y_q <= hold_y_d;
      hold_u_q <= hold_u_d;
      hold_v_q <= hold_v_d;
      data_q   <= data_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_yuv422_packer.sv
// Self-checking bench for yuv422_packer: directed and randomized lines checked
// against a whole-line packing model.
module tb_yuv422_packer;

  localparam int BW = 8;

  typedef struct packed {
    logic [BW-1:0] y;
    logic [BW-1:0] u;
    logic [BW-1:0] v;
  } px_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_ready;
  logic [BW-1:0]   i_y = '0;
  logic [BW-1:0]   i_u = '0;
  logic [BW-1:0]   i_v = '0;
  logic            i_last = 1'b0;
  logic            o_valid;
  logic            o_ready = 1'b0;
  logic [4*BW-1:0] o_data;
  logic            o_last;

  int              total = 0;
  int              bad = 0;
  int unsigned     cyc = 0;
  logic            rand_rdy = 1'b0;

  logic [4*BW:0]   got[$];
  int unsigned     got_cyc[$];
  logic [4*BW:0]   exp_q[$];
  px_t             line[$];

  yuv422_packer #(.BW(BW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_y(i_y), .i_u(i_u), .i_v(i_v), .i_last(i_last),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_last(o_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output transfer; o_ready/o_valid are stable from here to the next rising edge.
  always @(negedge clk) begin
    if (rst && o_valid && o_ready) begin
      got.push_back({o_last, o_data});
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [BW-1:0] avg(input int a, input int b);
    int s;
    s = (a + b + 1) / 2;
    return s[BW-1:0];
  endfunction

  // Whole-line view: word k covers pixels 2k and 2k+1; a lone final pixel is duplicated.
  function automatic void model_line();
    int n;
    n = line.size();
    for (int k = 0; k < n; k += 2) begin
      if (k + 1 < n)
        exp_q.push_back({(k + 2 == n), line[k].y,
                         avg(int'(line[k].u), int'(line[k+1].u)), line[k+1].y,
                         avg(int'(line[k].v), int'(line[k+1].v))});
      else
        exp_q.push_back({1'b1, line[k].y, line[k].u, line[k].y, line[k].v});
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) o_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_all();
    got.delete();
    got_cyc.delete();
    exp_q.delete();
    line.delete();
  endtask

  task automatic send_px(input px_t p, input logic last);
    int  n;
    logic ok;
    n = 0;
    i_valid = 1'b1;
    i_y = p.y;
    i_u = p.u;
    i_v = p.v;
    i_last = last;
    forever begin
      @(negedge clk);
      ok = i_ready;
      tick();
      if (ok) break;
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: i_ready=%0b after %0d cycles, required 1", i_ready, n);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic send_line();
    for (int i = 0; i < line.size(); i++) begin
      send_px(line[i], (i == line.size() - 1));
      if (rand_rdy) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_rdy = 1'b0;
    o_ready = 1'b1;
    while (o_valid && n < 50) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    o_ready = 1'b0;
    #3;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid: got=%b exp=0", o_valid); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL reset_o_data: got=%h exp=0", o_data); end
    total++; if (o_last !== 1'b0) begin bad++; $display("FAIL reset_o_last: got=%b exp=0", o_last); end
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready: got=%b exp=1", i_ready); end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_pair();
    clear_all();
    o_ready = 1'b1;
    send_px({8'd10, 8'd100, 8'd200}, 1'b0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pair_first_no_word: got o_valid=%b exp=0", o_valid); end
    send_px({8'd20, 8'd101, 8'd50}, 1'b1);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL pair_latency: got o_valid=%b exp=1", o_valid); end
    total++; if (o_data !== 32'h0A65147D) begin bad++; $display("FAIL pair_data: got=%h exp=0a65147d", o_data); end
    total++; if (o_last !== 1'b1) begin bad++; $display("FAIL pair_last: got=%b exp=1", o_last); end
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pair_single_word: got o_valid=%b exp=0", o_valid); end
    total++; if (got.size() !== 1) begin bad++; $display("FAIL pair_count: got=%0d exp=1", got.size()); end
  endtask

  task automatic test_odd_and_rounding();
    clear_all();
    o_ready = 1'b1;
    send_px({8'd5, 8'd6, 8'd7}, 1'b1);
    total++; if ({o_last, o_data} !== {1'b1, 32'h05060507}) begin
      bad++; $display("FAIL odd_pad: got=%b/%h exp=1/05060507", o_last, o_data); end
    line.push_back({8'd1, 8'd2, 8'd3});
    line.push_back({8'd4, 8'd6, 8'd8});
    model_line();
    send_line();
    line.delete();
    line.push_back({8'h11, 8'hFF, 8'h00});
    line.push_back({8'h22, 8'hFF, 8'h01});
    model_line();
    send_line();
    total++; if ({o_last, o_data} !== {1'b1, 32'h11FF2201}) begin
      bad++; $display("FAIL rounding_width: got=%b/%h exp=1/11ff2201", o_last, o_data); end
    drain();
    exp_q.push_front({1'b1, 32'h05060507});
    total++; if (got.size() !== exp_q.size()) begin bad++; $display("FAIL odd_count: got=%0d exp=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < got.size()) begin
      total++; if (got[k] !== exp_q[k]) begin bad++; $display("FAIL odd_word%0d: got=%h exp=%h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    px_t p3, p4;
    clear_all();
    o_ready = 1'b0;
    line.push_back(24'($urandom));
    line.push_back(24'($urandom));
    model_line();
    send_line();
    p3 = 24'($urandom);
    p4 = 24'($urandom);
    line.delete();
    line.push_back(p3);
    line.push_back(p4);
    model_line();
    i_valid = 1'b1;
    i_y = p3.y; i_u = p3.u; i_v = p3.v; i_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++; if (i_ready !== 1'b0) begin bad++; $display("FAIL bp_i_ready: got=%b exp=0", i_ready); end
      total++; if ({o_valid, o_last, o_data} !== {1'b1, exp_q[0]}) begin
        bad++; $display("FAIL bp_hold: got=%b/%h exp=1/%h", o_valid, {o_last, o_data}, exp_q[0]); end
    end
    @(posedge clk);
    #1;
    o_ready = 1'b1;
    #1;
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL bp_release_i_ready: got=%b exp=1", i_ready); end
    tick();
    send_px(p4, 1'b1);
    drain();
    total++; if (got.size() !== 2) begin bad++; $display("FAIL bp_count: got=%0d exp=2", got.size()); end
    foreach (exp_q[k]) if (k < got.size()) begin
      total++; if (got[k] !== exp_q[k]) begin bad++; $display("FAIL bp_word%0d: got=%h exp=%h", k, got[k], exp_q[k]); end
    end
  endtask

  task automatic test_streaming();
    clear_all();
    o_ready = 1'b1;
    for (int i = 0; i < 8; i++) line.push_back(24'($urandom));
    model_line();
    send_line();
    drain();
    total++; if (got.size() !== 4) begin bad++; $display("FAIL stream_count: got=%0d exp=4", got.size()); end
    foreach (exp_q[k]) if (k < got.size()) begin
      total++; if (got[k] !== exp_q[k]) begin bad++; $display("FAIL stream_word%0d: got=%h exp=%h", k, got[k], exp_q[k]); end
      if (k > 0) begin
        total++; if (got_cyc[k] - got_cyc[k-1] !== 2) begin
          bad++; $display("FAIL stream_spacing%0d: got=%0d exp=2", k, got_cyc[k] - got_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_reset_midpair();
    clear_all();
    o_ready = 1'b0;
    send_px(24'($urandom), 1'b1);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rst_pending_setup: got o_valid=%b exp=1", o_valid); end
    rst = 1'b0;
    #1;
    total++; if ({o_valid, o_data} !== '0) begin bad++; $display("FAIL rst_drop_word: got=%b/%h exp=0/0", o_valid, o_data); end
    tick();
    rst = 1'b1;
    o_ready = 1'b1;
    send_px(24'($urandom), 1'b0);
    rst = 1'b0;
    repeat (2) begin
      #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_midpair_o_valid: got=%b exp=0", o_valid); end
      tick();
    end
    rst = 1'b1;
    line.push_back(24'($urandom));
    line.push_back(24'($urandom));
    model_line();
    send_line();
    drain();
    total++; if (got.size() !== 1) begin bad++; $display("FAIL rst_count: got=%0d exp=1", got.size()); end
    if (got.size() > 0) begin
      total++; if (got[0] !== exp_q[0]) begin bad++; $display("FAIL rst_word: got=%h exp=%h", got[0], exp_q[0]); end
    end
  endtask

  task automatic test_random();
    clear_all();
    rand_rdy = 1'b1;
    for (int l = 0; l < 16; l++) begin
      line.delete();
      for (int i = 0; i < int'($urandom_range(1, 9)); i++) line.push_back(24'($urandom));
      model_line();
      rand_rdy = 1'b1;
      send_line();
    end
    drain();
    total++; if (got.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count: got=%0d exp=%0d", got.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < got.size()) begin
      total++; if (got[k] !== exp_q[k]) begin bad++; $display("FAIL rand_word%0d: got=%h exp=%h", k, got[k], exp_q[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_odd_and_rounding();
    test_backpressure();
    test_streaming();
    test_reset_midpair();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yuv422_packer.md
# yuv422_packer

Downstream stage of the RGB-to-YUV converter. It consumes a YUV 4:4:4 pixel stream over a valid/ready handshake and averages chroma over horizontal pixel pairs. It emits packed 4:2:2 words {Y0, U, Y1, V}, one word per two input pixels. Line ends are marked with a last flag, and odd-length lines are padded.

## Interface

Parameters:
- BW, 8, bit width of each Y/U/V component; output word is 4*BW.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset; one clock, asynchronous assert, active-low (rst=0 resets).
- i_valid  input  1  input pixel valid.
- i_ready  output  1  packer can accept a pixel this cycle.
- i_y, i_u, i_v  input  BW each  pixel components, unsigned (chroma offset-binary).
- i_last  input  1  pixel is the last of its line.
- o_valid  output  1  o_data/o_last hold a valid word.
- o_ready  input  1  downstream accepts the word this cycle.
- o_data  output  4*BW  packed word {Y0, U, Y1, V}, Y0 in MSBs.
- o_last  output  1  word contains the last pixel of a line.

## Operation

Handshakes:
- Input transfer: i_valid && i_ready at a rising edge.
- Output transfer: o_valid && o_ready at a rising edge.

Ready and stall:
- i_ready = !o_valid || o_ready, combinational from o_valid and o_ready only.
- i_ready never depends on i_valid.

State machine, two states:
- EVEN (reset state): no pixel held.
  - Accepted pixel with i_last=0: store Y0/U0/V0 in the hold register, go to ODD.
  - Accepted pixel with i_last=1: emit the padded word {Y0, U0, Y0, V0} with o_last=1, stay in EVEN.
- ODD: first pixel of a pair held.
  - Accepted pixel: emit {Y0, Uavg, Y1, Vavg} with o_last=i_last, go to EVEN.

Arithmetic:
- Uavg = (U0 + U1 + 1) >> 1, Vavg = (V0 + V1 + 1) >> 1.
- Sums use BW+1 bits; there is no overflow or saturation.
- The Y components pass through unmodified.

Output register:
- Loaded whenever a word is emitted; o_valid is set.
- Otherwise o_valid clears on an output transfer and holds when o_valid && !o_ready.
- While o_valid=1 and o_ready=0, o_data and o_last are stable.

Other rules:
- The hold register updates only on an input transfer in EVEN state.
- The state changes only on input transfers.
- Simultaneous output transfer and emission in one cycle: the new word replaces the old one and o_valid stays 1. Full throughput is one pixel per cycle.
- The i_y/i_u/i_v/i_last values are ignored when i_valid=0.
- A line starts in EVEN. A last pixel always returns the block to EVEN, so pairing never spans lines.

## Timing

- Reset (rst=0, asynchronous):
  - state=EVEN, o_valid=0, o_data=0, o_last=0, hold register=0.
  - i_ready=1 immediately, because o_valid=0.
- Reset mid-pair: a held first pixel is discarded, and a pending output word is dropped.
- Latency: a word is valid in the cycle after the edge that accepted its second pixel, or its single padded pixel.
- Sustained rate with o_ready=1: one word every 2 cycles on even-length lines.
- An odd-length line of N pixels produces ceil(N/2) words, and only the final word is padded.
- Backpressure: with o_ready=0 and o_valid=1, i_ready=0. No input is accepted and the state is frozen.
- When o_ready rises, i_ready rises in the same cycle.

## Test plan

- Pair packing: (Y=10,U=100,V=200,last=0) then (Y=20,U=101,V=50,last=1) with o_ready=1.
  - Expect one word 0x0A65147D with o_last=1, valid 1 cycle after the second transfer.
- Odd line: single pixel (Y=5,U=6,V=7,last=1).
  - Expect 0x05060507 with o_last=1.
  - Next pixel starts a fresh pair, still in EVEN.
- Rounding and width: U0=U1=255, V0=0, V1=1.
  - Expect U=0xFF and V=0x01; there is no wraparound.
- Backpressure: hold o_ready=0 for 5 cycles after a word is emitted while i_valid stays 1.
  - Expect i_ready=0 and o_data stable throughout.
  - Then o_ready=1: the word transfers and i_ready=1 in the same cycle, with no pixel lost or duplicated.
- Streaming: 8-pixel line with i_valid=1 and o_ready=1 every cycle.
  - Expect 4 words, o_valid on alternating cycles, o_last only on the 4th.
- Reset mid-pair: accept one pixel (last=0), pull rst=0 for 2 cycles, release, then send a full pair.
  - Expect o_valid=0 during reset and exactly one word, formed only from the post-reset pair.
